// File: rtl/lpf_decim.sv
// Rounds, saturates and decimates the fir result into Q15 and buffers it in a show-ahead FIFO.
// Latency: a kept sample accepted at edge N is written to the FIFO at edge N+2.
// Backpressure: none on the input; a full FIFO with no pop drops the new sample and sets ovf.

module lpf_decim_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] lvl_nxt;
    logic          pop;
    logic          full;
    logic          wr_en;

    // A pop frees the head slot, so a push into a full FIFO is legal in that same cycle.
    always_comb begin
        pop     = rd_vld & rd_rdy;
        full    = (level == LW'(DEPTH));
        wr_en   = wr_vld & (~full | pop);
        drop    = wr_vld & full & ~pop;
        lvl_nxt = level + LW'(wr_en) - LW'(pop);
    end

    // Pointers, occupancy and the registered not-empty flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            level  <= lvl_nxt;
            rd_vld <= (lvl_nxt != '0);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
endmodule

module lpf_decim #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 15,
    parameter int DECIM  = 4,
    parameter int SKIP   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_W-1:0]     din,
    input  logic                        din_valid,
    input  logic                        clr,
    output logic signed [DOUT_W-1:0]    dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        sat,
    output logic                        ovf
);
    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
    // Width of the rounded, shifted value before saturation.
    localparam int RW  = DIN_W + 1 - SHIFT;
    localparam int HW  = RW - DOUT_W + 1;
    localparam logic [DIN_W:0]    HALF = (DIN_W + 1)'(1) << (SHIFT - 1);
    localparam logic [DOUT_W-1:0] MAXV = {1'b0, {(DOUT_W - 1){1'b1}}};
    localparam logic [DOUT_W-1:0] MINV = {1'b1, {(DOUT_W - 1){1'b0}}};

    logic [SKW-1:0]    skip_cnt;
    logic [PHW-1:0]    phase;
    logic              skip_done;
    logic              keep;
    logic [DIN_W:0]    sum;
    logic              rnd_unused;
    logic              s1_vld;
    logic [RW-1:0]     s1_r;
    logic [HW-1:0]     hi;
    logic              pos_clip;
    logic              neg_clip;
    logic [DOUT_W-1:0] sat_val;
    logic              s2_vld;
    logic [DOUT_W-1:0] s2_dat;
    logic              fifo_drop;
    logic [DOUT_W-1:0] fifo_dat;

    assign skip_done = (skip_cnt == SKW'(SKIP));
    assign keep      = din_valid & skip_done & (phase == '0);

    // Sign-extend by one bit so adding the half-LSB can never wrap; the shift
    // then just takes the top bits, which is floor division (half rounds up).
    assign sum        = {din[DIN_W-1], din} + HALF;
    assign rnd_unused = ^sum[SHIFT-1:0];

    // Discard counter: saturates at SKIP, after which every accepted sample is eligible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         skip_cnt <= '0;
        else if (din_valid && !skip_done) skip_cnt <= skip_cnt + SKW'(1);
    end

    // Decimation phase: only advances once the start-up transient is gone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (din_valid && skip_done) begin
            phase <= (phase == PHW'(DECIM - 1)) ? '0 : phase + PHW'(1);
        end
    end

    // Stage 1: register the rounded and shifted value of kept samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
        end else begin
            s1_vld <= keep;
            if (keep) s1_r <= sum[DIN_W:SHIFT];
        end
    end

    // Bits that must all match the output sign bit for the value to fit.
    always_comb begin
        hi       = s1_r[RW-1:DOUT_W-1];
        pos_clip = ~s1_r[RW-1] & (|hi);
        neg_clip = s1_r[RW-1] & ~(&hi);
        sat_val  = s1_r[DOUT_W-1:0];
        if (pos_clip) sat_val = MAXV;
        if (neg_clip) sat_val = MINV;
    end

    // Stage 2: register the saturated sample that is pushed on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) s2_dat <= sat_val;
        end
    end

    // Sticky flags: a new event in the clearing cycle takes priority over clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (s1_vld && (pos_clip || neg_clip)) sat <= 1'b1;
            else if (clr)                         sat <= 1'b0;
            if (fifo_drop)                        ovf <= 1'b1;
            else if (clr)                         ovf <= 1'b0;
        end
    end

    lpf_decim_fifo #(
        .W     (DOUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s2_vld),
        .wr_dat (s2_dat),
        .rd_vld (dout_valid),
        .rd_rdy (dout_ready),
        .rd_dat (fifo_dat),
        .level  (level),
        .drop   (fifo_drop)
    );

    assign dout = fifo_dat;
endmodule

// File: tb/tb_lpf_decim.sv
// Bench for lpf_decim: two instances (DECIM=1/SKIP=0 and DECIM=4/SKIP=4) share stimulus.
// Directed scenarios plus a randomized run against a queue-based reference model.
// Outputs are sampled 1 time unit after each rising edge.

module tb_lpf_decim;
    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        din;
    logic               din_valid;
    logic               clr;
    logic               dout_ready;
    logic signed [15:0] dout_a, dout_b;
    logic               dv_a, dv_b;
    logic [3:0]         lvl_a, lvl_b;
    logic               sat_a, sat_b, ovf_a, ovf_b;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    typedef struct {
        int due;
        int val;
        bit clip;
    } pend_t;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int    fq [2][$];
    pend_t pq [2][$];
    int    acc [2];
    bit    sat_m [2];
    bit    ovf_m [2];

    lpf_decim #(.DECIM(1), .SKIP(0)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
        .level(lvl_a), .sat(sat_a), .ovf(ovf_a)
    );

    lpf_decim #(.DECIM(4), .SKIP(4)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
        .level(lvl_b), .sat(sat_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    function automatic int dec_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int skip_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    // Round half up to Q15 then clamp to 16 bits, using floor division.
    function automatic void quantise(input logic [31:0] x, output int val, output bit clip);
        longint num;
        longint q;
        num = longint'($signed(x)) + 64'sd16384;
        q   = num / 64'sd32768;
        if (num < 0 && (num % 64'sd32768) != 0) q = q - 1;
        clip = (q > 32767) || (q < -32768);
        if (q > 32767)       val = 32767;
        else if (q < -32768) val = -32768;
        else                 val = int'(q);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            fq[d].delete();
            pq[d].delete();
            acc[d]   = 0;
            sat_m[d] = 1'b0;
            ovf_m[d] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs that were present at it.
    task automatic model_edge();
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit    pop, push, sat_ev, ovf_ev, c;
            int    pv, v, idx;
            pend_t p;
            pop  = (fq[d].size() > 0) && dout_ready;
            push = 1'b0;
            pv   = 0;
            if (pq[d].size() > 0 && pq[d][0].due == edge_no) begin
                push = 1'b1;
                pv   = pq[d][0].val;
                void'(pq[d].pop_front());
            end
            ovf_ev = push && (fq[d].size() == 8) && !pop;
            sat_ev = 1'b0;
            foreach (pq[d][i]) if (pq[d][i].due == edge_no + 1 && pq[d][i].clip) sat_ev = 1'b1;
            if (pop) void'(fq[d].pop_front());
            if (push && !ovf_ev) fq[d].push_back(pv);
            sat_m[d] = sat_ev ? 1'b1 : (clr ? 1'b0 : sat_m[d]);
            ovf_m[d] = ovf_ev ? 1'b1 : (clr ? 1'b0 : ovf_m[d]);
            if (din_valid) begin
                idx = acc[d];
                acc[d]++;
                if (idx >= skip_of(d) && ((idx - skip_of(d)) % dec_of(d)) == 0) begin
                    quantise(din, v, c);
                    p.due  = edge_no + 2;
                    p.val  = v;
                    p.clip = c;
                    pq[d].push_back(p);
                end
            end
        end
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic r, input logic c);
        din        = d;
        din_valid  = v;
        dout_ready = r;
        clr        = c;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step(32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            vectors++;
            if ({dout_a, dv_a, lvl_a, sat_a, ovf_a} !== 23'd0) begin
                miscompares++;
                $display("FAIL reset_a: got dout=%0d vld=%b lvl=%0d sat=%b ovf=%b want all 0",
                         dout_a, dv_a, lvl_a, sat_a, ovf_a);
            end
            vectors++;
            if ({dout_b, dv_b, lvl_b, sat_b, ovf_b} !== 23'd0) begin
                miscompares++;
                $display("FAIL reset_b: got dout=%0d vld=%b lvl=%0d sat=%b ovf=%b want all 0",
                         dout_b, dv_b, lvl_b, sat_b, ovf_b);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_round_sat();
        logic [31:0] stim [5];
        int          want [5];
        int          got [$];
        stim = '{32'h0000_4000, 32'hFFFF_C000, 32'h3FFF_8000, 32'h4000_0000, 32'h8000_0000};
        want = '{1, 0, 32767, 32767, -32768};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 5) step(stim[i], 1'b1, 1'b1, 1'b0);
            else       step(32'd0, 1'b0, 1'b1, 1'b0);
            if (dv_a) begin
                got.push_back(int'(dout_a));
                if (got.size() == 1) begin
                    vectors++;
                    if (sat_a !== 1'b0) begin
                        miscompares++;
                        $display("FAIL sat_early: got %b want 0", sat_a);
                    end
                end
                if (got.size() == 4) begin
                    vectors++;
                    if (sat_a !== 1'b1) begin
                        miscompares++;
                        $display("FAIL sat_on_4th: got %b want 1", sat_a);
                    end
                end
            end
        end
        vectors++;
        if (got.size() != 5) begin
            miscompares++;
            $display("FAIL round_count: got %0d want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vectors++;
            if (got[i] != want[i]) begin
                miscompares++;
                $display("FAIL round_val[%0d]: got %0d want %0d", i, got[i], want[i]);
            end
        end
        step(32'd0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (sat_a !== 1'b0 || ovf_a !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clr: got sat=%b ovf=%b want 0 0", sat_a, ovf_a);
        end
    endtask

    task automatic test_decim();
        int got [$];
        int want [4];
        int acc_edge;
        int first_edge;
        want       = '{4, 8, 12, 16};
        acc_edge   = -1;
        first_edge = -1;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            if (k < 20) step(32'(k) << 15, 1'b1, 1'b1, 1'b0);
            else        step(32'd0, 1'b0, 1'b1, 1'b0);
            if (k == 4) acc_edge = edge_no;
            if (dv_b) begin
                if (first_edge < 0) first_edge = edge_no;
                got.push_back(int'(dout_b));
            end
        end
        vectors++;
        if (first_edge != acc_edge + 2) begin
            miscompares++;
            $display("FAIL decim_latency: valid after edge %0d want %0d", first_edge, acc_edge + 2);
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL decim_count: got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vectors++;
            if (got[i] != want[i]) begin
                miscompares++;
                $display("FAIL decim_val[%0d]: got %0d want %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int v = 1; v <= 10; v++) step(32'(v) << 15, 1'b1, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (lvl_a !== 4'd8 || ovf_a !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: got level=%0d ovf=%b want 8 1", lvl_a, ovf_a);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (dv_a !== 1'b1 || int'(dout_a) != i + 1) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got vld=%b dout=%0d want 1 %0d", i, dv_a, dout_a, i + 1);
            end
            step(32'd0, 1'b0, 1'b1, 1'b0);
        end
        vectors++;
        if (dv_a !== 1'b0 || lvl_a !== 4'd0) begin
            miscompares++;
            $display("FAIL bp_empty: got vld=%b level=%0d want 0 0", dv_a, lvl_a);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int v = 1; v <= 9; v++) step(32'(v) << 15, 1'b1, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (lvl_a !== 4'd8) begin
            miscompares++;
            $display("FAIL fp_fill: got level=%0d want 8", lvl_a);
        end
        step(32'd0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (lvl_a !== 4'd8 || ovf_a !== 1'b0 || int'(dout_a) != 2) begin
            miscompares++;
            $display("FAIL fp_simul: got level=%0d ovf=%b dout=%0d want 8 0 2", lvl_a, ovf_a, dout_a);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (dv_a !== 1'b1 || int'(dout_a) != i + 2) begin
                miscompares++;
                $display("FAIL fp_drain[%0d]: got vld=%b dout=%0d want 1 %0d", i, dv_a, dout_a, i + 2);
            end
            step(32'd0, 1'b0, 1'b1, 1'b0);
        end
        vectors++;
        if (dv_a !== 1'b0) begin
            miscompares++;
            $display("FAIL fp_empty: got vld=%b want 0", dv_a);
        end
    endtask

    task automatic test_mid_reset();
        int got_a [$];
        int got_b [$];
        do_reset();
        for (int v = 1; v <= 3; v++) step(32'(v + 20) << 15, 1'b1, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (lvl_a !== 4'd3) begin
            miscompares++;
            $display("FAIL mr_pre: got level=%0d want 3", lvl_a);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dv_a !== 1'b0 || lvl_a !== 4'd0 || dout_a !== 16'sd0) begin
            miscompares++;
            $display("FAIL mr_async: got vld=%b level=%0d dout=%0d want 0 0 0", dv_a, lvl_a, dout_a);
        end
        #2;
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k < 12) step(32'(k) << 15, 1'b1, 1'b1, 1'b0);
            else        step(32'd0, 1'b0, 1'b1, 1'b0);
            if (dv_a) got_a.push_back(int'(dout_a));
            if (dv_b) got_b.push_back(int'(dout_b));
        end
        vectors++;
        if (got_b.size() != 2 || got_b[0] != 4) begin
            miscompares++;
            $display("FAIL mr_skip_b: got count=%0d first=%0d want 2 4",
                     got_b.size(), (got_b.size() > 0) ? got_b[0] : -1);
        end
        vectors++;
        if (got_a.size() != 12 || got_a[0] != 0) begin
            miscompares++;
            $display("FAIL mr_restart_a: got count=%0d first=%0d want 12 0",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : -1);
        end
    endtask

    task automatic test_random();
        int          rdy_pct;
        logic [31:0] d;
        do_reset();
        rdy_pct = 50;
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) rdy_pct = (n % 300 == 0) ? 15 : ((n % 300 == 100) ? 50 : 95);
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'($urandom_range(0, 1 << 23)) - 32'(1 << 22);
                2:       d = 32'((int'($urandom_range(0, 200)) - 100) * 32768 + 16384);
                default: d = 32'(32767 * 32768) + 32'($urandom_range(0, 65535)) - 32'd32768;
            endcase
            step(d, 1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < rdy_pct),
                 1'($urandom_range(0, 99) < 5));
            for (int k = 0; k < 2; k++) begin
                logic signed [15:0] a_dout;
                logic               a_dv, a_sat, a_ovf;
                logic [3:0]         a_lvl;
                a_dout = (k == 0) ? dout_a : dout_b;
                a_dv   = (k == 0) ? dv_a   : dv_b;
                a_lvl  = (k == 0) ? lvl_a  : lvl_b;
                a_sat  = (k == 0) ? sat_a  : sat_b;
                a_ovf  = (k == 0) ? ovf_a  : ovf_b;
                vectors++;
                if (a_dv !== (fq[k].size() > 0)) begin
                    miscompares++;
                    $display("FAIL rnd_vld[%0d] cyc %0d: got %b want %b", k, n, a_dv, fq[k].size() > 0);
                end
                vectors++;
                if (a_lvl !== 4'(fq[k].size())) begin
                    miscompares++;
                    $display("FAIL rnd_level[%0d] cyc %0d: got %0d want %0d", k, n, a_lvl, fq[k].size());
                end
                if (fq[k].size() > 0) begin
                    vectors++;
                    if (int'(a_dout) != fq[k][0]) begin
                        miscompares++;
                        $display("FAIL rnd_dout[%0d] cyc %0d: got %0d want %0d", k, n, a_dout, fq[k][0]);
                    end
                end
                vectors++;
                if (a_sat !== sat_m[k] || a_ovf !== ovf_m[k]) begin
                    miscompares++;
                    $display("FAIL rnd_flags[%0d] cyc %0d: got sat=%b ovf=%b want %b %b",
                             k, n, a_sat, a_ovf, sat_m[k], ovf_m[k]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        clr        = 1'b0;
        dout_ready = 1'b0;
        model_reset();
        test_reset();
        test_round_sat();
        test_decim();
        test_backpressure();
        test_full_pop();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lpf_decim.md
# lpf_decim

Output conditioning stage placed directly downstream of the `fir` low-pass filter. It consumes the filter's 32-bit signed full-precision result every clock and discards the start-up transient while the tap line fills. It rounds and saturates each sample back to 16-bit Q15, decimates by a fixed factor and buffers results in a small FIFO behind a valid/ready output handshake, so a slower sink can take the band-limited, down-sampled stream.

## Interface
- `DIN_W`, 32: input width; matches `fir` `f_out`.
- `DOUT_W`, 16: output width.
- `SHIFT`, 15: right-shift applied after rounding (Q15 coefficient scale); range 1..DIN_W-DOUT_W+1.
- `DECIM`, 4: decimation factor, ≥1.
- `SKIP`, 4: number of accepted input samples discarded after reset; 0 allowed.
- `DEPTH`, 8: FIFO depth, power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `din` in DIN_W: signed sample, wired to `fir.f_out`.
- `din_valid` in 1: sample present this cycle. There is no input backpressure.
- `clr` in 1: synchronous clear of the sticky flags.
- `dout` out DOUT_W: signed FIFO head sample.
- `dout_valid` out 1: FIFO not empty.
- `dout_ready` in 1: sink accepts the head this cycle.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `sat` out 1: sticky flag; a kept sample was clipped.
- `ovf` out 1: sticky flag; a kept sample was dropped because the FIFO was full.

## Operation
Samples are accepted on each rising edge with `din_valid`=1.

Skip counter:
- Counts accepted samples from 0 up to SKIP.
- While it is below SKIP, accepted samples are discarded.
- The phase counter does not advance during this period.

Phase counter:
- Runs 0..DECIM-1 and wraps after DECIM-1.
- Advances on every accepted, non-skipped sample.
- A sample is kept when phase==0, so the first sample after the skip period is kept.

Stage 1 (registered):
- Computes r = (din + 2^(SHIFT-1)) >>> SHIFT.
- The addition is done in DIN_W+1 bits with sign extension, so it never wraps.
- Rounding is half up: +0.5 LSB goes up, -0.5 LSB goes to 0.

Stage 2 (registered):
- Saturates r to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
- If clipped, sets `sat`.
- Pushes the result into the FIFO.

FIFO:
- Show-ahead: `dout` always equals the head entry.
- A pop happens when `dout_valid` and `dout_ready` are both 1 at a rising edge.
- Push while full with no pop: the new sample is dropped, the FIFO contents are unchanged and `ovf` is set.
- Push while full with a simultaneous pop: both take effect, nothing is dropped and `level` stays at DEPTH.
- Push into an empty FIFO with `dout_ready`=1: the sample still becomes visible for at least one cycle. There is no bypass.
- `dout_ready` while empty is ignored.

Sticky flags:
- `clr`=1 clears `sat` and `ovf` at the edge.
- If a new event occurs in the same cycle as `clr`, the event wins and the flag reads 1.

Reset:
- Asserting `rst` low, at any time, immediately clears the skip counter, the phase counter, both pipeline valids, the FIFO pointers, `level`, `sat`, `ovf`, `dout_valid`, and sets `dout`=0.
- In-flight samples are lost.
- After release, the SKIP discard period starts again.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `level`=0, `sat`=0, `ovf`=0.
- Latency: a kept sample accepted at edge N is written to the FIFO at edge N+2. `dout_valid` and `level` reflect it after edge N+2.
- Throughput: one input per clock. With DECIM=1 and `dout_ready` held at 1, one output per clock with no gaps after the pipeline fills.
- Updates: `level` and `dout_valid` are registered and update on the same edge as the push/pop.
- Reset release: the first edge after `rst` deasserts is treated as a normal edge.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 and toggle `din`/`din_valid`.
  - Required response: all outputs stay at reset values; `level`=0.
- Rounding and saturation (DECIM=1, SKIP=0, ready=1):
  - Stimulus: din=16384, -16384, 0x3FFF8000, 0x40000000, 0x80000000.
  - Required response: dout=1, 0, 32767, 32767, -32768.
  - `sat` first goes to 1 on the fourth output; `clr` returns it to 0.
- Decimation (DECIM=4, SKIP=4):
  - Stimulus: din=k·2^15 for k=0..19, one per clock.
  - Required response: exactly dout=4, 8, 12, 16.
  - For din=4·2^15 accepted at edge N, `dout_valid` rises after edge N+2.
- Backpressure (DECIM=1, SKIP=0):
  - Stimulus: ready=0 while pushing values 1..10, then ready=1.
  - Required response: `level` stops at 8 and `ovf`=1. Output is 1..8 in order, one per clock, then `dout_valid`=0.
- Full with simultaneous pop:
  - Stimulus: fill to 8, then push 9 with ready=1 in the same cycle.
  - Required response: pop 1, 9 is stored, `level` stays 8, `ovf` stays 0.
- Mid-stream reset:
  - Stimulus: pull `rst` low between edges with the FIFO holding 3 entries.
  - Required response: `dout_valid` and `level` drop to 0 immediately. After release, the first SKIP samples are discarded again.
